// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module : spi_slave
// SPI responder that turns rw/address/data frames into register write strobes
// and read requests.
// Rev    : 1.0
// ============================================================================
module spi_slave #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clock_polarity,
    input  logic                     clock_phase,
    input  logic                     serial_clock,
    input  logic                     chip_select,
    input  logic                     serial_in,
    output logic                     serial_out,
    output logic                     serial_out_enable,
    output logic                     write_valid,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     read_request,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic                     busy,
    output logic                     frame_error
);

    localparam int                 c_CNT_W      = $clog2(ADDRESS_WIDTH + DATA_WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_CMD_LAST   = c_CNT_W'(ADDRESS_WIDTH);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(ADDRESS_WIDTH + DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COMMAND    = 3'd1,
        S_WRITE_DATA = 3'd2,
        S_READ_DATA  = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_cs_sync;
    logic [SYNC_STAGES-1:0]   r_sdi_sync;
    logic [SYNC_STAGES-1:0]   r_sync_valid;
    logic                     r_sclk_prev;
    logic                     r_armed;

    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic [ADDRESS_WIDTH-1:0] r_cmd;
    logic [DATA_WIDTH-1:0]    r_shift;

    logic                     r_serial_out;
    logic                     r_write_valid;
    logic                     r_read_request;
    logic                     r_frame_error;
    logic [ADDRESS_WIDTH-1:0] r_write_address;
    logic [ADDRESS_WIDTH-1:0] r_read_address;
    logic [DATA_WIDTH-1:0]    r_write_data;

    logic                     w_sclk;
    logic                     w_cs_active;
    logic                     w_busy;
    logic                     w_sdi;
    logic                     w_lead;
    logic                     w_trail;
    logic                     w_sample;
    logic                     w_shift;
    logic [ADDRESS_WIDTH:0]   w_cmd_next;
    logic [DATA_WIDTH-1:0]    w_data_next;

    logic                     w_cnt_clr;
    logic                     w_cnt_inc;
    logic                     w_cmd_shift;
    logic                     w_data_shift;
    logic                     w_tx_shift;
    logic                     w_write_done;
    logic                     w_read_req;
    logic                     w_abort;

    // serial_clock is normalised against CPOL before synchronising, so idle is
    // always 0: leading edge = rise, trailing edge = fall.
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_active = ~r_cs_sync[SYNC_STAGES-1];
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
    assign w_lead      = w_sclk & ~r_sclk_prev;
    assign w_trail     = ~w_sclk & r_sclk_prev;
    assign w_sample    = clock_phase ? w_trail : w_lead;
    assign w_shift     = clock_phase ? w_lead : w_trail;
    assign w_busy      = w_cs_active & r_armed;
    assign w_cmd_next  = {r_cmd, w_sdi};
    assign w_data_next = {r_shift[DATA_WIDTH-2:0], w_sdi};

    // r_armed only sets once a genuine high chip_select has passed the
    // synchronizer, so a reset in mid-frame waits for a fresh falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sclk_sync  <= '0;
            r_cs_sync    <= '1;
            r_sdi_sync   <= '0;
            r_sync_valid <= '0;
            r_sclk_prev  <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], serial_clock ^ clock_polarity};
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], chip_select};
            r_sdi_sync   <= {r_sdi_sync[SYNC_STAGES-2:0], serial_in};
            r_sync_valid <= {r_sync_valid[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev  <= w_sclk;
            if (r_sync_valid[SYNC_STAGES-1] && !w_cs_active) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cmd_shift  = 1'b0;
        w_data_shift = 1'b0;
        w_tx_shift   = 1'b0;
        w_write_done = 1'b0;
        w_read_req   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_busy) begin
                    w_state_next = S_COMMAND;
                end
            end
            S_COMMAND: begin
                if (!w_cs_active) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_sample) begin
                    w_cmd_shift = 1'b1;
                    w_cnt_inc   = 1'b1;
                    if (r_bit_cnt == c_CMD_LAST) begin
                        if (w_cmd_next[ADDRESS_WIDTH]) begin
                            w_read_req   = 1'b1;
                            w_state_next = S_READ_DATA;
                        end else begin
                            w_state_next = S_WRITE_DATA;
                        end
                    end
                end
            end
            S_WRITE_DATA: begin
                if (!w_cs_active) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_sample) begin
                    w_data_shift = 1'b1;
                    w_cnt_inc    = 1'b1;
                    if (r_bit_cnt == c_FRAME_LAST) begin
                        w_write_done = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_READ_DATA: begin
                if (!w_cs_active) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    if (w_sample) begin
                        w_cnt_inc = 1'b1;
                        if (r_bit_cnt == c_FRAME_LAST) begin
                            w_state_next = S_DONE;
                        end
                    end
                    if (w_shift) begin
                        w_tx_shift = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!w_cs_active) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One shift register serves both directions: it fills from MOSI on writes
    // and is loaded from read_data, then drained MSB-first, on reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_cnt       <= '0;
            r_cmd           <= '0;
            r_shift         <= '0;
            r_serial_out    <= 1'b0;
            r_write_valid   <= 1'b0;
            r_read_request  <= 1'b0;
            r_frame_error   <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_read_address  <= '0;
        end else begin
            r_write_valid  <= w_write_done;
            r_read_request <= w_read_req;
            r_frame_error  <= w_abort;

            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end

            if (w_cmd_shift) begin
                r_cmd <= w_cmd_next[ADDRESS_WIDTH-1:0];
            end
            if (w_read_req) begin
                r_read_address <= w_cmd_next[ADDRESS_WIDTH-1:0];
            end

            if (r_read_request) begin
                r_shift <= read_data;
            end else if (w_data_shift) begin
                r_shift <= w_data_next;
            end else if (w_tx_shift) begin
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_write_done) begin
                r_write_address <= r_cmd;
                r_write_data    <= w_data_next;
            end

            if (w_state_next != S_READ_DATA) begin
                r_serial_out <= 1'b0;
            end else if (w_tx_shift) begin
                r_serial_out <= r_shift[DATA_WIDTH-1];
            end
        end
    end

    assign serial_out        = r_serial_out;
    assign serial_out_enable = w_busy;
    assign busy              = w_busy;
    assign write_valid       = r_write_valid;
    assign write_address     = r_write_address;
    assign write_data        = r_write_data;
    assign read_request      = r_read_request;
    assign read_address      = r_read_address;
    assign frame_error       = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// Testbench for spi_slave: directed and random SPI frames checked against a
// transaction-level model of the expected strobes and MISO word.
module tb_spi_slave;

    logic        clock;
    logic        reset;
    logic        clock_polarity;
    logic        clock_phase;
    logic        serial_clock;
    logic        chip_select;
    logic        serial_in;
    logic        serial_out;
    logic        serial_out_enable;
    logic        write_valid;
    logic [14:0] write_address;
    logic [15:0] write_data;
    logic        read_request;
    logic [14:0] read_address;
    logic [15:0] read_data;
    logic        busy;
    logic        frame_error;

    int          checks;
    int          errors;
    int          wv_cnt;
    int          rr_cnt;
    int          fe_cnt;
    logic [30:0] wq[$];
    logic [14:0] rq[$];
    logic [15:0] next_read_value;

    spi_slave #(
        .DATA_WIDTH    (16),
        .ADDRESS_WIDTH (15),
        .SYNC_STAGES   (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .clock_polarity    (clock_polarity),
        .clock_phase       (clock_phase),
        .serial_clock      (serial_clock),
        .chip_select       (chip_select),
        .serial_in         (serial_in),
        .serial_out        (serial_out),
        .serial_out_enable (serial_out_enable),
        .write_valid       (write_valid),
        .write_address     (write_address),
        .write_data        (write_data),
        .read_request      (read_request),
        .read_address      (read_address),
        .read_data         (read_data),
        .busy              (busy),
        .frame_error       (frame_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Strobe monitor: every strobe cycle is counted, so a stretched pulse shows up.
    initial begin
        wv_cnt = 0;
        rr_cnt = 0;
        fe_cnt = 0;
        forever begin
            @(negedge clock);
            if (write_valid === 1'b1) begin
                wv_cnt++;
                wq.push_back({write_address, write_data});
            end
            if (read_request === 1'b1) begin
                rr_cnt++;
                rq.push_back(read_address);
            end
            if (frame_error === 1'b1) fe_cnt++;
        end
    end

    // Read responder: data valid only during the one cycle after read_request.
    initial begin
        read_data = 16'h0000;
        forever begin
            @(negedge clock);
            if (read_request === 1'b1) begin
                read_data = next_read_value;
                @(negedge clock);
                read_data = 16'($urandom);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_mode(input logic cp, input logic ph);
        @(negedge clock);
        clock_polarity = cp;
        serial_clock   = cp;
        clock_phase    = ph;
        wait_clk(4);
    endtask

    // kind: 0 = full frame, 1 = chip_select raised after stop bits, 2 = reset after stop bits
    task automatic do_frame(input logic [31:0] frame, input int stop, input int kind,
                            input int gap, output logic [31:0] miso);
        int half;
        miso = 32'h0;
        half = $urandom_range(4, 6);
        @(negedge clock);
        chip_select = 1'b0;
        serial_in   = frame[31];
        wait_clk(half);
        for (int i = 0; i < 32; i++) begin
            if (i >= stop) break;
            if (i == 1) check("busy_in_frame", {busy, serial_out_enable}, 2'b11);
            if (clock_phase == 1'b0) begin
                serial_clock = ~clock_polarity;
                miso[31-i]   = serial_out;
                wait_clk(half);
                serial_clock = clock_polarity;
                if (i < 31) serial_in = frame[30-i];
                wait_clk(half);
            end else begin
                serial_clock = ~clock_polarity;
                serial_in    = frame[31-i];
                wait_clk(half);
                serial_clock = clock_polarity;
                miso[31-i]   = serial_out;
                wait_clk(half);
            end
        end
        if (kind == 2) begin
            reset = 1'b1;
            @(negedge clock);
            check("reset_outputs",
                  {serial_out, serial_out_enable, write_valid, write_address, write_data,
                   read_request, read_address, busy, frame_error}, 64'h0);
            wait_clk(2);
            reset = 1'b0;
            wait_clk(6);
            check("no_restart_after_reset", {busy, serial_out_enable}, 2'b00);
        end
        chip_select  = 1'b1;
        serial_clock = clock_polarity;
        wait_clk(gap);
    endtask

    task automatic run_frame(input string tag, input logic rw, input logic [14:0] addr,
                             input logic [15:0] wd, input logic [15:0] rv,
                             input int stop, input int kind, input int gap);
        int          wv0;
        int          rr0;
        int          fe0;
        logic [31:0] miso;
        logic [31:0] mask;
        logic [31:0] exp_miso;
        logic [30:0] went;
        logic        complete;
        logic        exp_write;
        logic        exp_read;
        wv0 = wv_cnt;
        rr0 = rr_cnt;
        fe0 = fe_cnt;
        next_read_value = rv;
        do_frame({rw, addr, wd}, stop, kind, gap, miso);
        complete  = (stop >= 32);
        exp_write = !rw && complete;
        exp_read  = rw && (stop >= 16);
        mask      = complete ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> stop);
        exp_miso  = (rw ? {16'h0000, rv} : 32'h0) & mask;
        check({tag, "/miso"}, miso, exp_miso);
        check({tag, "/write_count"}, wv_cnt - wv0, exp_write ? 1 : 0);
        if (exp_write && wq.size() > 0) begin
            went = wq.pop_front();
            check({tag, "/write_address"}, went[30:16], addr);
            check({tag, "/write_data"}, went[15:0], wd);
        end
        check({tag, "/read_count"}, rr_cnt - rr0, exp_read ? 1 : 0);
        if (exp_read && rq.size() > 0) begin
            check({tag, "/read_address"}, rq.pop_front(), addr);
        end
        check({tag, "/frame_error_count"}, fe_cnt - fe0, (kind == 1 && !complete) ? 1 : 0);
        wq.delete();
        rq.delete();
    endtask

    initial begin
        logic [1:0]  m;
        logic        rw;
        int          stop;
        checks          = 0;
        errors          = 0;
        next_read_value = 16'h0000;
        reset           = 1'b1;
        clock_polarity  = 1'b0;
        clock_phase     = 1'b0;
        serial_clock    = 1'b0;
        chip_select     = 1'b1;
        serial_in       = 1'b0;
        wait_clk(3);
        check("reset_state",
              {serial_out, serial_out_enable, write_valid, write_address, write_data,
               read_request, read_address, busy, frame_error}, 64'h0);
        reset = 1'b0;
        wait_clk(5);

        set_mode(1'b0, 1'b0);
        run_frame("m0_write", 1'b0, 15'h1111, 16'hA5C3, 16'h0000, 32, 0, 8);
        run_frame("m0_read", 1'b1, 15'h0022, 16'h0000, 16'hBEEF, 32, 0, 8);

        set_mode(1'b1, 1'b1);
        run_frame("m3_write", 1'b0, 15'h7FFF, 16'h0001, 16'h0000, 32, 0, 8);
        run_frame("m3_read", 1'b1, 15'h7FFF, 16'h0000, 16'h0001, 32, 0, 8);

        set_mode(1'b0, 1'b0);
        run_frame("abort10", 1'b0, 15'h0009, 16'hCAFE, 16'h0000, 10, 1, 8);
        run_frame("after_abort", 1'b0, 15'h0005, 16'h1234, 16'h0000, 32, 0, 8);

        run_frame("reset20", 1'b1, 15'h0040, 16'h0000, 16'h9C31, 20, 2, 8);
        run_frame("after_reset", 1'b1, 15'h0001, 16'h0000, 16'h5A5A, 32, 0, 8);

        run_frame("b2b_first", 1'b0, 15'h0003, 16'hFFFF, 16'h0000, 32, 0, 2);
        run_frame("b2b_second", 1'b0, 15'h0004, 16'h0000, 16'h0000, 32, 0, 8);

        for (int n = 0; n < 12; n++) begin
            m    = 2'($urandom_range(0, 3));
            rw   = 1'($urandom);
            stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            set_mode(m[1], m[0]);
            run_frame("random", rw, 15'($urandom), 16'($urandom), 16'($urandom),
                      stop, (stop < 32) ? 1 : 0, 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
